imem_refill_unit: RTL and testbench



---
 rtl/imem_refill_unit_pkg.sv | 14 +
 rtl/imem_refill_ctr.sv | 26 ++
 rtl/imem_refill_unit.sv | 125 ++++++++++++
 tb/tb_imem_refill_unit.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_refill_unit_pkg.sv
// Shared constants and types for the instruction-cache line refill unit.
package imem_refill_unit_pkg;

    // Default line geometry: words per line and byte-offset bits inside a line.
    localparam int unsigned line_words       = 4;
    localparam int unsigned line_offset_bits = $clog2(line_words) + 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } refill_state_t;

endpackage

// File: rtl/imem_refill_ctr.sv
// Saturating up-counter with synchronous clear; used for the issue and receive word indices.
module refill_ctr #(
    parameter int unsigned W       = 3,
    parameter int unsigned MAX_VAL = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] TOP = W'(MAX_VAL);

    // Clear wins over increment; the count sticks at TOP.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != TOP)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/imem_refill_unit.sv
// Instruction-cache miss refill: fetches one aligned line from RAM over a pipelined
// req/gnt/rvalid bus, keeping up to MAX_OUT requests in flight, and streams the words
// back in ascending order.
module imem_refill_unit
    import imem_refill_unit_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned LINE_WORDS = line_words,
    parameter int unsigned MAX_OUT    = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              miss,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic [WORD_W-1:0] mem_word,
    output logic              word_ready,
    output logic [ADDR_W-1:0] word_addr,
    output logic              line_done,
    output logic              busy,
    output logic              ram_req,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_gnt,
    input  logic              ram_rvalid,
    input  logic [WORD_W-1:0] ram_rdata
);

    localparam int unsigned LB = $clog2(LINE_WORDS) + 2;
    localparam int unsigned CW = $clog2(LINE_WORDS) + 1;
    localparam int unsigned OW = $clog2(MAX_OUT) + 1;

    localparam logic [CW-1:0] LINE_CNT = CW'(LINE_WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(LINE_WORDS - 1);
    localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUT);

    refill_state_t     state;
    logic [ADDR_W-1:0] base;
    logic [OW-1:0]     out_cnt;
    logic [CW-1:0]     iss_cnt;
    logic [CW-1:0]     rcv_cnt;

    logic start;
    logic grant;
    logic accept;

    // Offset bits of the faulting address are dropped when the line base is latched.
    logic unused_addr_bits;
    assign unused_addr_bits = ^miss_addr[LB-1:0];

    // Request side is combinational from registered state, so it holds until granted.
    always_comb begin
        start    = (state == IDLE) && miss;
        ram_req  = (state == FILL) && (iss_cnt < LINE_CNT) && (out_cnt < OUT_MAX);
        ram_addr = (state == FILL) ? base + ADDR_W'({iss_cnt, 2'b00}) : '0;
        grant    = ram_req && ram_gnt;
        // A response with nothing outstanding (stale or spurious) is dropped.
        accept   = (state == FILL) && ram_rvalid && (out_cnt != '0);
        busy     = (state != IDLE);
    end

    refill_ctr #(
        .W       (CW),
        .MAX_VAL (LINE_WORDS)
    ) u_iss_ctr (
        .clk  (clk),
        .nrst (nrst),
        .clr  (start),
        .inc  (grant),
        .cnt  (iss_cnt)
    );

    refill_ctr #(
        .W       (CW),
        .MAX_VAL (LINE_WORDS)
    ) u_rcv_ctr (
        .clk  (clk),
        .nrst (nrst),
        .clr  (start),
        .inc  (accept),
        .cnt  (rcv_cnt)
    );

    // Refill FSM with registered word/line outputs and the outstanding-request count.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            base       <= '0;
            out_cnt    <= '0;
            mem_word   <= '0;
            word_addr  <= '0;
            word_ready <= 1'b0;
            line_done  <= 1'b0;
        end else begin
            word_ready <= 1'b0;
            line_done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (miss) begin
                        base    <= {miss_addr[ADDR_W-1:LB], {LB{1'b0}}};
                        out_cnt <= '0;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    out_cnt <= out_cnt + OW'(grant) - OW'(accept);
                    if (accept) begin
                        word_ready <= 1'b1;
                        mem_word   <= ram_rdata;
                        word_addr  <= base + ADDR_W'({rcv_cnt, 2'b00});
                        if (rcv_cnt == LAST_IDX) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // One dead cycle so the cache can drop miss after the last write.
                    line_done <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_refill_unit.sv
// Self-checking bench for imem_refill_unit: a latency-configurable RAM model plus
// per-scenario tasks comparing the refill stream against the expected line contents.
`timescale 1ns/1ps
module tb_imem_refill_unit;
    import imem_refill_unit_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned WW = 32;
    localparam int unsigned LW = line_words;
    localparam int unsigned MO = 2;
    localparam logic [AW-1:0] LINE_MASK = ~((AW'(1) << line_offset_bits) - AW'(1));

    logic          clk;
    logic          nrst;
    logic          miss;
    logic [AW-1:0] miss_addr;
    logic [WW-1:0] mem_word;
    logic          word_ready;
    logic [AW-1:0] word_addr;
    logic          line_done;
    logic          busy;
    logic          ram_req;
    logic [AW-1:0] ram_addr;
    logic          ram_gnt;
    logic          ram_rvalid;
    logic [WW-1:0] ram_rdata;

    imem_refill_unit #(
        .ADDR_W     (AW),
        .WORD_W     (WW),
        .LINE_WORDS (LW),
        .MAX_OUT    (MO)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .miss       (miss),
        .miss_addr  (miss_addr),
        .mem_word   (mem_word),
        .word_ready (word_ready),
        .word_addr  (word_addr),
        .line_done  (line_done),
        .busy       (busy),
        .ram_req    (ram_req),
        .ram_addr   (ram_addr),
        .ram_gnt    (ram_gnt),
        .ram_rvalid (ram_rvalid),
        .ram_rdata  (ram_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int miss_cyc = 0;

    // RAM model controls
    int            lat        = 1;
    bit            gnt_rand   = 0;
    int            stall_idx  = -1;
    int            stall_left = 0;
    logic [AW-1:0] stall_addr = '0;
    bit            spurious   = 0;

    // RAM model state and observation logs
    int            pend_due[$];
    logic [AW-1:0] pend_addr[$];
    int            b_out = 0, b_prev = 0, max_out = 0, full_req = 0, unstable = 0;
    int            stall_seen = 0, stall_bad = 0;
    bit            held = 0;
    logic [AW-1:0] held_addr = '0;
    logic [AW-1:0] gnt_addr[$];
    int            gnt_cyc[$];
    logic [WW-1:0] wr_data[$];
    logic [AW-1:0] wr_addr[$];
    int            wr_cyc[$];
    int            ld_cyc[$];

    function automatic logic [WW-1:0] ram_fn(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model and monitor: everything sampled and driven on the falling edge.
    initial begin
        ram_gnt    = 1'b0;
        ram_rvalid = 1'b0;
        ram_rdata  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            b_prev = b_out;
            if (word_ready === 1'b1) begin
                wr_data.push_back(mem_word);
                wr_addr.push_back(word_addr);
                wr_cyc.push_back(cyc);
            end
            if (line_done === 1'b1) ld_cyc.push_back(cyc);
            if (!nrst) held = 0;
            else if (held && (ram_req !== 1'b1 || ram_addr !== held_addr)) unstable++;
            ram_rvalid = 1'b0;
            ram_rdata  = '0;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                ram_rvalid = 1'b1;
                ram_rdata  = ram_fn(pend_addr[0]);
                void'(pend_due.pop_front());
                void'(pend_addr.pop_front());
                if (b_out > 0) b_out--;
            end else if (spurious) begin
                ram_rvalid = 1'b1;
                ram_rdata  = 32'hDEAD_BEEF;
                spurious   = 0;
            end
            ram_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (ram_req === 1'b1 && stall_left > 0 && gnt_addr.size() == stall_idx) begin
                ram_gnt = 1'b0;
                stall_left--;
                stall_seen++;
                if (ram_addr !== stall_addr) stall_bad++;
            end
            if (ram_req === 1'b1 && b_prev >= MO) full_req++;
            if (ram_req === 1'b1 && ram_gnt) begin
                pend_due.push_back(cyc + lat);
                pend_addr.push_back(ram_addr);
                gnt_addr.push_back(ram_addr);
                gnt_cyc.push_back(cyc);
                b_out++;
                if (b_out > max_out) max_out = b_out;
            end
            held      = nrst && (ram_req === 1'b1) && !ram_gnt;
            held_addr = ram_addr;
        end
    end

    task automatic clear_logs();
        gnt_addr.delete();
        gnt_cyc.delete();
        wr_data.delete();
        wr_addr.delete();
        wr_cyc.delete();
        ld_cyc.delete();
        max_out    = 0;
        full_req   = 0;
        unstable   = 0;
        stall_seen = 0;
        stall_bad  = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic start_miss(input logic [AW-1:0] a);
        @(negedge clk);
        #1;
        miss      = 1'b1;
        miss_addr = a;
        miss_cyc  = cyc;
    endtask

    // hold: 0 drop miss once sampled, 1 drop at line_done, 2 leave it high
    task automatic wait_done(input int budget, input int hold, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (hold == 0 && i == 0) begin
                miss      = 1'b0;
                miss_addr = $urandom;
            end
            if (ld_cyc.size() > 0) begin
                ok = 1;
                if (hold == 1) miss = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b1;
        #1 nrst = 1'b0;
        #1;
        n_checks++;
        if ({busy, ram_req, word_ready, line_done} === 4'b0) n_pass++;
        else $display("FAIL reset_ctrl: got %b, expected 0000",
                      {busy, ram_req, word_ready, line_done});
        n_checks++;
        if ({mem_word, word_addr, ram_addr} === '0) n_pass++;
        else $display("FAIL reset_data: got word=%h waddr=%h raddr=%h, expected all 0",
                      mem_word, word_addr, ram_addr);
        repeat (3) @(negedge clk);
        #2 nrst = 1'b1;
        wait_cycles(2);
    endtask

    task automatic test_basic();
        bit ok;
        logic [AW-1:0] base = 32'h0000_1230;
        clear_logs();
        lat = 1;
        start_miss(32'h0000_1234);
        wait_done(40, 1, ok);
        n_checks++;
        if (ok) n_pass++; else $display("FAIL basic_done: got no line_done, expected one");
        n_checks++;
        if (gnt_addr.size() == LW) n_pass++;
        else $display("FAIL basic_req_count: got %0d, expected %0d", gnt_addr.size(), LW);
        for (int i = 0; i < LW; i++) begin
            logic [AW-1:0] ea = base + AW'(4 * i);
            n_checks++;
            if (i < gnt_addr.size() && gnt_addr[i] === ea) n_pass++;
            else $display("FAIL basic_ram_addr%0d: got %h, expected %h", i, gnt_addr[i], ea);
        end
        n_checks++;
        if (gnt_cyc.size() > 0 && gnt_cyc[0] - miss_cyc == 1) n_pass++;
        else $display("FAIL basic_first_req: got %0d, expected 1",
                      gnt_cyc.size() > 0 ? gnt_cyc[0] - miss_cyc : -1);
        for (int i = 0; i < LW; i++) begin
            logic [AW-1:0] ea = base + AW'(4 * i);
            n_checks++;
            if (i < wr_addr.size() && wr_addr[i] === ea && wr_data[i] === ram_fn(ea)) n_pass++;
            else $display("FAIL basic_word%0d: got addr=%h data=%h, expected addr=%h data=%h",
                          i, wr_addr[i], wr_data[i], ea, ram_fn(ea));
        end
        n_checks++;
        if (wr_cyc.size() == LW && wr_cyc[LW-1] - wr_cyc[0] == LW - 1) n_pass++;
        else $display("FAIL basic_consecutive: got %0d words over %0d cycles, expected %0d/%0d",
                      wr_cyc.size(), wr_cyc.size() > 0 ? wr_cyc[wr_cyc.size()-1] - wr_cyc[0] : -1,
                      LW, LW - 1);
        // Edges counted from the edge that samples miss to the edge raising line_done.
        n_checks++;
        if (ld_cyc.size() > 0 && ld_cyc[0] - miss_cyc - 1 == LW + 2) n_pass++;
        else $display("FAIL basic_line_done_time: got %0d, expected %0d",
                      ld_cyc.size() > 0 ? ld_cyc[0] - miss_cyc - 1 : -1, LW + 2);
        wait_cycles(3);
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [AW-1:0] base = 32'h0000_1230;
        clear_logs();
        lat        = 1;
        stall_idx  = 1;
        stall_left = 3;
        stall_addr = 32'h0000_1234;
        start_miss(32'h0000_1234);
        wait_done(40, 1, ok);
        stall_idx = -1;
        n_checks++;
        if (ok && stall_seen == 3 && stall_bad == 0 && unstable == 0) n_pass++;
        else $display("FAIL bp_hold: got done=%0d stalls=%0d bad_addr=%0d unstable=%0d, expected 1/3/0/0",
                      ok, stall_seen, stall_bad, unstable);
        for (int i = 0; i < LW; i++) begin
            logic [AW-1:0] ea = base + AW'(4 * i);
            n_checks++;
            if (i < wr_addr.size() && wr_addr[i] === ea && wr_data[i] === ram_fn(ea) &&
                i < gnt_addr.size() && gnt_addr[i] === ea) n_pass++;
            else $display("FAIL bp_word%0d: got req=%h addr=%h data=%h, expected %h data=%h",
                          i, gnt_addr[i], wr_addr[i], wr_data[i], ea, ram_fn(ea));
        end
        wait_cycles(3);
    endtask

    task automatic test_outstanding();
        bit ok;
        logic [AW-1:0] base = 32'h0000_2A50;
        clear_logs();
        lat = 4;
        start_miss(32'h0000_2A5C);
        wait_done(60, 1, ok);
        n_checks++;
        if (ok && max_out == MO && full_req == 0) n_pass++;
        else $display("FAIL out_limit: got done=%0d max_out=%0d req_when_full=%0d, expected 1/%0d/0",
                      ok, max_out, full_req, MO);
        n_checks++;
        if (wr_addr.size() == LW && wr_addr[LW-1] === base + AW'(4 * (LW - 1)) &&
            wr_data[0] === ram_fn(base)) n_pass++;
        else $display("FAIL out_words: got n=%0d last=%h first_data=%h, expected n=%0d last=%h",
                      wr_addr.size(), wr_addr[LW-1], wr_data[0], LW, base + AW'(4 * (LW - 1)));
        wait_cycles(3);
    endtask

    task automatic test_simul();
        bit ok;
        int errs = 0;
        logic [AW-1:0] base = 32'h0008_0000;
        clear_logs();
        lat = 2;
        start_miss(32'h0008_0008);
        wait_done(40, 1, ok);
        wait_cycles(4);
        for (int i = 0; i < LW; i++) begin
            logic [AW-1:0] ea = base + AW'(4 * i);
            if (i >= wr_addr.size() || wr_addr[i] !== ea || wr_data[i] !== ram_fn(ea)) errs++;
        end
        n_checks++;
        if (ok && wr_addr.size() == LW && errs == 0) n_pass++;
        else $display("FAIL simul_words: got done=%0d n=%0d bad=%0d, expected 1/%0d/0",
                      ok, wr_addr.size(), errs, LW);
        n_checks++;
        if (max_out <= MO && full_req == 0 && busy === 1'b0 && ram_req === 1'b0) n_pass++;
        else $display("FAIL simul_out: got max_out=%0d req_when_full=%0d busy=%b req=%b, expected <=%0d/0/0/0",
                      max_out, full_req, busy, ram_req, MO);
        wait_cycles(2);
    endtask

    task automatic test_idle_done();
        bit ok = 0;
        int errs = 0;
        logic [AW-1:0] base = 32'h0000_0F00;
        clear_logs();
        lat      = 1;
        spurious = 1;
        wait_cycles(4);
        n_checks++;
        if (wr_data.size() == 0 && busy === 1'b0) n_pass++;
        else $display("FAIL idle_spurious: got words=%0d busy=%b, expected 0/0",
                      wr_data.size(), busy);
        start_miss(32'h0000_0F04);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #1;
            if (ld_cyc.size() >= 2) begin
                ok = 1;
                break;
            end
        end
        miss = 1'b0;
        n_checks++;
        if (ok && gnt_cyc.size() == 2 * LW && gnt_cyc[LW] - ld_cyc[0] == 1) n_pass++;
        else $display("FAIL done_restart: got done=%0d grants=%0d gap=%0d, expected 1/%0d/1",
                      ok, gnt_cyc.size(), gnt_cyc.size() > LW ? gnt_cyc[LW] - ld_cyc[0] : -1, 2 * LW);
        for (int i = 0; i < 2 * LW; i++) begin
            logic [AW-1:0] ea = base + AW'(4 * (i % LW));
            if (i >= wr_addr.size() || wr_addr[i] !== ea || wr_data[i] !== ram_fn(ea)) errs++;
        end
        n_checks++;
        if (wr_addr.size() == 2 * LW && errs == 0) n_pass++;
        else $display("FAIL done_words: got n=%0d bad=%0d, expected %0d/0",
                      wr_addr.size(), errs, 2 * LW);
        wait_cycles(3);
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [AW-1:0] base = 32'h0000_0040;
        clear_logs();
        lat = 1;
        start_miss(32'h0000_1110);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            if (wr_data.size() >= 2) break;
        end
        nrst  = 1'b0;
        miss  = 1'b0;
        b_out = 0;
        #1;
        n_checks++;
        if ({busy, ram_req, word_ready, line_done} === 4'b0 &&
            {mem_word, word_addr, ram_addr} === '0) n_pass++;
        else $display("FAIL midreset_outputs: got ctrl=%b word=%h waddr=%h raddr=%h, expected 0",
                      {busy, ram_req, word_ready, line_done}, mem_word, word_addr, ram_addr);
        @(negedge clk);
        #2 nrst = 1'b1;
        wait_cycles(5);
        n_checks++;
        if (wr_data.size() == 2 && ld_cyc.size() == 0 && busy === 1'b0) n_pass++;
        else $display("FAIL midreset_late_rvalid: got words=%0d done=%0d busy=%b, expected 2/0/0",
                      wr_data.size(), ld_cyc.size(), busy);
        clear_logs();
        start_miss(32'h0000_0040);
        wait_done(40, 1, ok);
        for (int i = 0; i < LW; i++) begin
            logic [AW-1:0] ea = base + AW'(4 * i);
            n_checks++;
            if (ok && i < wr_addr.size() && wr_addr[i] === ea && wr_data[i] === ram_fn(ea)) n_pass++;
            else $display("FAIL midreset_refill%0d: got addr=%h data=%h, expected addr=%h data=%h",
                          i, wr_addr[i], wr_data[i], ea, ram_fn(ea));
        end
        wait_cycles(3);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            bit ok;
            int errs = 0;
            logic [AW-1:0] a = $urandom;
            logic [AW-1:0] base = a & LINE_MASK;
            clear_logs();
            lat      = $urandom_range(1, 4);
            gnt_rand = 1;
            start_miss(a);
            wait_done(200, 0, ok);
            wait_cycles(lat + 2);
            for (int i = 0; i < LW; i++) begin
                logic [AW-1:0] ea = base + AW'(4 * i);
                if (i >= gnt_addr.size() || gnt_addr[i] !== ea) errs++;
                if (i >= wr_addr.size() || wr_addr[i] !== ea || wr_data[i] !== ram_fn(ea)) errs++;
            end
            n_checks++;
            if (ok && errs == 0 && wr_addr.size() == LW && gnt_addr.size() == LW) n_pass++;
            else $display("FAIL rand%0d_line: got done=%0d bad=%0d words=%0d reqs=%0d base=%h lat=%0d",
                          n, ok, errs, wr_addr.size(), gnt_addr.size(), base, lat);
            n_checks++;
            if (max_out <= MO && full_req == 0 && unstable == 0) n_pass++;
            else $display("FAIL rand%0d_bus: got max_out=%0d req_when_full=%0d unstable=%0d, expected <=%0d/0/0",
                          n, max_out, full_req, unstable, MO);
        end
        gnt_rand = 0;
        wait_cycles(2);
    endtask

    initial begin
        nrst      = 1'b1;
        miss      = 1'b0;
        miss_addr = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_outstanding();
        test_simul();
        test_idle_done();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
